axi_lite_ctrl_mc: RTL and testbench

Multi-channel AXI-Lite control/status slave: the parametrised successor of the single-core control wrapper. It drives NUM_CH matrix compute cores from one AXI-Lite port, with per-channel M/K/N configuration, start pulses, sticky done, busy tracking, byte strobes, error responses and a combined interrupt. It sits between the host AXI-Lite interconnect and the compute-core array.

---
 rtl/axi_lite_ctrl_mc.sv | 209 ++++++++++++++++++++
 tb/tb_axi_lite_ctrl_mc.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_ctrl_mc.sv
// AXI-Lite control/status slave for NUM_CH matrix compute cores.
// Per-channel CFG_M/K/N, start pulse, sticky DONE, BUSY tracking and a combined interrupt.
module axi_lite_ctrl_mc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic                  s_axi_bvalid,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [NUM_CH*32-1:0]  cfg_m,
  output logic [NUM_CH*32-1:0]  cfg_k,
  output logic [NUM_CH*32-1:0]  cfg_n,
  output logic [NUM_CH-1:0]     start,
  input  logic [NUM_CH-1:0]     done,
  output logic                  irq
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_CH * 32);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshake rule: a channel transfers on a rising edge where valid and ready are both high;
  // valid, once raised, is held with stable payload until that edge.
  logic                 aw_held;
  logic [ADDR_W-1:0]    aw_addr;
  logic                 w_held;
  logic [DATA_W-1:0]    w_data;
  logic [DATA_W/8-1:0]  w_strb;
  logic                 ar_held;
  logic [ADDR_W-1:0]    ar_addr;

  logic [NUM_CH-1:0]    busy_r;
  logic [NUM_CH-1:0]    done_r;
  logic [NUM_CH-1:0]    irq_en_r;
  logic [NUM_CH*32-1:0] cfg_m_r;
  logic [NUM_CH*32-1:0] cfg_k_r;
  logic [NUM_CH*32-1:0] cfg_n_r;

  function automatic logic dec_err(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_LIMIT) || (a[4:0] > 5'h14) || (a[1:0] != 2'b00);
  endfunction

  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid && !ar_held;

  logic       commit;
  logic       wr_err;
  logic [2:0] wr_ch;
  logic [4:0] wr_off;
  logic       wr_busy;
  logic       start_req;
  logic       start_err;
  logic       start_ok;
  logic       wr_ok;

  assign commit    = aw_held && w_held;
  assign wr_err    = dec_err(aw_addr);
  assign wr_ch     = aw_addr[7:5];
  assign wr_off    = aw_addr[4:0];
  assign start_req = commit && !wr_err && (wr_off == 5'h00) && w_strb[0] && w_data[0];
  assign start_err = start_req && wr_busy;
  assign start_ok  = start_req && !wr_busy;
  assign wr_ok     = commit && !wr_err && !start_err;

  always_comb begin
    wr_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == 3'(c)) wr_busy = busy_r[c];
    end
  end

  logic       rd_err;
  logic [2:0] rd_ch;
  logic [4:0] rd_off;
  logic [31:0] rd_val;

  assign rd_err = dec_err(ar_addr);
  assign rd_ch  = ar_addr[7:5];
  assign rd_off = ar_addr[4:0];

  always_comb begin
    rd_val = 32'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rd_err && rd_ch == 3'(c)) begin
        case (rd_off)
          5'h04:   rd_val = {30'h0, busy_r[c], done_r[c]};
          5'h08:   rd_val = cfg_m_r[32*c +: 32];
          5'h0C:   rd_val = cfg_k_r[32*c +: 32];
          5'h10:   rd_val = cfg_n_r[32*c +: 32];
          5'h14:   rd_val = {31'h0, irq_en_r[c]};
          default: rd_val = 32'h0;
        endcase
      end
    end
  end

  // Bus-side state: holding registers and response channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held      <= 1'b0;
      aw_addr      <= '0;
      w_held       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      ar_held      <= 1'b0;
      ar_addr      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= RESP_OKAY;
      s_axi_rdata  <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (wr_err || start_err) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        ar_held <= 1'b1;
        ar_addr <= s_axi_araddr;
      end
      if (ar_held) begin
        ar_held      <= 1'b0;
        s_axi_rvalid <= 1'b1;
        s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        s_axi_rdata  <= rd_val;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // Register file; a core done pulse is applied last so it wins over a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= '0;
      done_r   <= '0;
      irq_en_r <= '0;
      cfg_m_r  <= '0;
      cfg_k_r  <= '0;
      cfg_n_r  <= '0;
      start    <= '0;
    end else begin
      start <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ok && wr_ch == 3'(c)) begin
          case (wr_off)
            5'h00: begin
              if (start_ok) begin
                start[c]  <= 1'b1;
                busy_r[c] <= 1'b1;
                done_r[c] <= 1'b0;
              end
            end
            5'h04: if (w_strb[0] && w_data[0]) done_r[c] <= 1'b0;
            5'h08: for (int b = 0; b < 4; b++)
                     if (w_strb[b]) cfg_m_r[32*c+8*b +: 8] <= w_data[8*b +: 8];
            5'h0C: for (int b = 0; b < 4; b++)
                     if (w_strb[b]) cfg_k_r[32*c+8*b +: 8] <= w_data[8*b +: 8];
            5'h10: for (int b = 0; b < 4; b++)
                     if (w_strb[b]) cfg_n_r[32*c+8*b +: 8] <= w_data[8*b +: 8];
            5'h14: if (w_strb[0]) irq_en_r[c] <= w_data[0];
            default: ;
          endcase
        end
        if (done[c] && busy_r[c]) begin
          busy_r[c] <= 1'b0;
          done_r[c] <= 1'b1;
        end
      end
    end
  end

  assign cfg_m = cfg_m_r;
  assign cfg_k = cfg_k_r;
  assign cfg_n = cfg_n_r;
  assign irq   = |(done_r & irq_en_r);

endmodule

// File: tb/tb_axi_lite_ctrl_mc.sv
// Directed bench for axi_lite_ctrl_mc: CFG access, strobes, start/done/busy, irq, decode errors, reset.
module tb_axi_lite_ctrl_mc;

  localparam int NUM_CH = 4;

  logic                 clk;
  logic                 rst_n;
  logic [31:0]          awaddr;
  logic                 awvalid;
  logic                 awready;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;
  logic                 wvalid;
  logic                 wready;
  logic                 bvalid;
  logic [1:0]           bresp;
  logic                 bready;
  logic [31:0]          araddr;
  logic                 arvalid;
  logic                 arready;
  logic [31:0]          rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;
  logic [NUM_CH*32-1:0] cfg_m;
  logic [NUM_CH*32-1:0] cfg_k;
  logic [NUM_CH*32-1:0] cfg_n;
  logic [NUM_CH-1:0]    start;
  logic [NUM_CH-1:0]    done;
  logic                 irq;

  axi_lite_ctrl_mc #(.DATA_W(32), .ADDR_W(32), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .start(start), .done(done), .irq(irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt [NUM_CH];
  int b_hs_cnt = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) if (start[i]) start_cnt[i]++;
    if (bvalid && bready) b_hs_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_aw(input logic [31:0] addr);
    logic ok = 1'b0;
    @(negedge clk);
    awaddr  = addr;
    awvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (awready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) awvalid = 1'b0;
      else @(negedge clk);
    end
    check_val("aw_handshake", 32'(ok), 32'd1);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    logic ok = 1'b0;
    @(negedge clk);
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (wready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) wvalid = 1'b0;
      else @(negedge clk);
    end
    check_val("w_handshake", 32'(ok), 32'd1);
    wvalid = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    logic ok = 1'b0;
    resp   = 2'b11;
    bready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin
        ok   = 1'b1;
        resp = bresp;
      end
    end
    @(posedge clk);
    #1;
    bready = 1'b0;
    check_val("b_arrives", 32'(ok), 32'd1);
  endtask

  // AW and W presented together; done_inj is asserted on the commit edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [NUM_CH-1:0] done_inj, output logic [1:0] resp);
    logic aw_ok = 1'b0;
    logic w_ok  = 1'b0;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    for (int i = 0; i < 50 && !(aw_ok && w_ok); i++) begin
      if (awvalid && awready) aw_ok = 1'b1;
      if (wvalid && wready) w_ok = 1'b1;
      @(posedge clk);
      #1;
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      if (!(aw_ok && w_ok)) @(negedge clk);
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_val("wr_handshake", 32'(aw_ok && w_ok), 32'd1);
    if (done_inj != '0) begin
      done = done_inj;
      @(posedge clk);
      #1;
      done = '0;
    end
    get_b(resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic ok = 1'b0;
    data = 32'hDEADBEEF;
    resp = 2'b11;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (arready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) arvalid = 1'b0;
      else @(negedge clk);
    end
    arvalid = 1'b0;
    check_val("ar_handshake", 32'(ok), 32'd1);
    ok = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) begin
        ok   = 1'b1;
        data = rdata;
        resp = rresp;
      end
    end
    @(posedge clk);
    #1;
    rready = 1'b0;
    check_val("r_arrives", 32'(ok), 32'd1);
  endtask

  task automatic pulse_done(input int ch);
    @(negedge clk);
    done[ch] = 1'b1;
    @(negedge clk);
    done = '0;
  endtask

  // Scoreboard: read expectations are queued, then drained against the DUT
  logic [31:0] exp_q[$];
  logic [31:0] addr_q[$];

  task automatic read_expect(input logic [31:0] addr, input logic [31:0] exp_data,
                             input logic [1:0] exp_resp, input string tag);
    logic [31:0] d;
    logic [1:0]  r;
    exp_q.push_back(exp_data);
    addr_q.push_back(addr);
    do_read(addr, d, r);
    check_val({tag, "_rdata"}, d, exp_q.pop_front());
    void'(addr_q.pop_front());
    check_val({tag, "_rresp"}, 32'(r), 32'(exp_resp));
  endtask

  logic [1:0]  resp;
  int          s0;
  int          bh0;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; done = '0;
    for (int i = 0; i < NUM_CH; i++) start_cnt[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_val("rst_bvalid", 32'(bvalid), 32'd0);
    check_val("rst_rvalid", 32'(rvalid), 32'd0);
    check_val("rst_readies", {29'h0, awready, wready, arready}, 32'h7);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_start", 32'(start), 32'd0);
    check_val("rst_cfg_m0", cfg_m[31:0], 32'd0);

    // Channel 2 CFG write / readback
    do_write(32'h48, 32'd4, 4'hF, '0, resp); check_val("cfgm2_bresp", 32'(resp), 32'd0);
    do_write(32'h4C, 32'd5, 4'hF, '0, resp); check_val("cfgk2_bresp", 32'(resp), 32'd0);
    do_write(32'h50, 32'd6, 4'hF, '0, resp); check_val("cfgn2_bresp", 32'(resp), 32'd0);
    check_val("cfg_m2_out", cfg_m[95:64], 32'd4);
    check_val("cfg_k2_out", cfg_k[95:64], 32'd5);
    check_val("cfg_n2_out", cfg_n[95:64], 32'd6);
    read_expect(32'h48, 32'd4, 2'b00, "rd_cfgm2");
    read_expect(32'h4C, 32'd5, 2'b00, "rd_cfgk2");
    read_expect(32'h50, 32'd6, 2'b00, "rd_cfgn2");

    // W ahead of AW, then a byte-lane write
    bh0 = b_hs_cnt;
    send_w(32'hABCD, 4'hF);
    repeat (3) @(posedge clk);
    check_val("early_w_no_b", 32'(bvalid), 32'd0);
    send_aw(32'h28);
    get_b(resp);
    check_val("late_aw_bresp", 32'(resp), 32'd0);
    check_val("cfg_m1_out", cfg_m[63:32], 32'hABCD);
    do_write(32'h08, 32'hABCD, 4'b0010, '0, resp);
    check_val("strb_bresp", 32'(resp), 32'd0);
    check_val("cfg_m0_strb", cfg_m[31:0], 32'h0000AB00);
    check_val("b_count", 32'(b_hs_cnt - bh0), 32'd2);

    // Start / busy / done on channel 0
    s0 = start_cnt[0];
    do_write(32'h00, 32'd1, 4'hF, '0, resp);
    check_val("start0_bresp", 32'(resp), 32'd0);
    check_val("start0_pulse", 32'(start_cnt[0] - s0), 32'd1);
    read_expect(32'h04, 32'h2, 2'b00, "status0_busy");
    read_expect(32'h00, 32'h0, 2'b00, "ctrl0_reads0");
    do_write(32'h00, 32'd1, 4'hF, '0, resp);
    check_val("start0_busy_bresp", 32'(resp), 32'd2);
    check_val("start0_busy_nopulse", 32'(start_cnt[0] - s0), 32'd1);
    pulse_done(0);
    read_expect(32'h04, 32'h1, 2'b00, "status0_done");

    // Interrupt on channel 3
    do_write(32'h74, 32'd1, 4'hF, '0, resp);
    do_write(32'h60, 32'd1, 4'hF, '0, resp);
    check_val("start3_pulse", 32'(start_cnt[3]), 32'd1);
    check_val("irq_before_done", 32'(irq), 32'd0);
    pulse_done(3);
    check_val("irq_after_done", 32'(irq), 32'd1);
    do_write(32'h64, 32'd1, 4'hF, '0, resp);
    check_val("irq_after_w1c", 32'(irq), 32'd0);
    do_write(32'h60, 32'd1, 4'hF, '0, resp);
    check_val("restart3_bresp", 32'(resp), 32'd0);
    do_write(32'h64, 32'd1, 4'hF, 4'b1000, resp);
    read_expect(32'h64, 32'h1, 2'b00, "status3_set_wins");
    check_val("irq_set_wins", 32'(irq), 32'd1);

    // Decode errors
    read_expect(32'h18, 32'h0, 2'b10, "rd_off18");
    read_expect(32'h0A, 32'h0, 2'b10, "rd_misalign");
    read_expect(32'h80, 32'h0, 2'b10, "rd_range");
    do_write(32'h18, 32'hFFFFFFFF, 4'hF, '0, resp); check_val("wr_off18", 32'(resp), 32'd2);
    do_write(32'h0A, 32'hFFFFFFFF, 4'hF, '0, resp); check_val("wr_misalign", 32'(resp), 32'd2);
    do_write(32'h80, 32'hFFFFFFFF, 4'hF, '0, resp); check_val("wr_range", 32'(resp), 32'd2);
    check_val("err_cfg_m0_kept", cfg_m[31:0], 32'h0000AB00);
    read_expect(32'h14, 32'h0, 2'b00, "err_irq_en0_kept");
    read_expect(32'h08, 32'h0000AB00, 2'b00, "err_cfgm0_kept");

    // Reset while a write response is pending
    send_aw(32'h4C);
    send_w(32'd7, 4'hF);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (bvalid) seen = 1'b1;
      end
      check_val("pend_bvalid", 32'(seen), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_bvalid", 32'(bvalid), 32'd0);
    check_val("rst_async_cfg_k2", cfg_k[95:64], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_readies", {29'h0, awready, wready, arready}, 32'h7);
    check_val("post_rst_irq", 32'(irq), 32'd0);
    for (int c = 0; c < NUM_CH; c++) begin
      for (int o = 0; o <= 5; o++) begin
        read_expect(32'(c * 32 + o * 4), 32'h0, 2'b00, "post_rst_reg");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
